fsm_burst_rd: RTL and testbench

- Parametrised burst read controller; successor to the single-word go/ws read handshake FSM.
- On `go`, issues `burst_len` consecutive reads starting at `start_addr`, honouring memory wait states (`ws`) per word.
- Captures returned data, signals completion (`ds`), and supports a wait-state timeout and an abort.
- Sits between a requesting master and a synchronous memory or peripheral port.

---
 rtl/fsm_burst_rd_if.sv | 31 +++
 rtl/fsm_burst_rd.sv | 71 +++++++
 tb/tb_fsm_burst_rd.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fsm_burst_rd_if.sv
// Request/memory bundle for the burst read controller.
// The slave modport is the controller's view; master is the requester plus memory.
interface fsm_burst_rd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              go;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              ws;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              ds;
    logic              busy;
    logic              err;

    modport slave (
        input  go, abort, start_addr, burst_len, ws, mem_rdata,
        output rd, addr, data_out, data_valid, ds, busy, err
    );

    modport master (
        output go, abort, start_addr, burst_len, ws, mem_rdata,
        input  rd, addr, data_out, data_valid, ds, busy, err
    );
endinterface

// File: rtl/fsm_burst_rd.sv
// Burst read controller: issues burst_len reads from start_addr, stalls on ws,
// times out after MAX_WAIT wait cycles per word, and can be aborted mid-burst.
module fsm_burst_rd #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    fsm_burst_rd_if.slave bus
);
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [2:0] {IDLE, READ, DLY, DONE, ERR} state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [WAIT_W-1:0] wait_cnt;

    assign bus.rd   = (state == READ) || (state == DLY);
    assign bus.busy = (state != IDLE);
    assign bus.ds   = (state == DONE);
    assign bus.err  = (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            remaining      <= '0;
            wait_cnt       <= '0;
            bus.addr       <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go && (bus.burst_len != '0)) begin
                        bus.addr  <= bus.start_addr;
                        remaining <= bus.burst_len;
                        state     <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    state    <= bus.abort ? IDLE : DLY;
                end
                DLY: begin
                    // abort wins over a word arriving in the same cycle
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (!bus.ws) begin
                        bus.data_out   <= bus.mem_rdata;
                        bus.data_valid <= 1'b1;
                        bus.addr       <= bus.addr + 1'b1;
                        remaining      <= remaining - 1'b1;
                        state          <= (remaining == LEN_W'(1)) ? DONE : READ;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if ((MAX_WAIT != 0) && (wait_cnt == WAIT_LAST))
                            state <= ERR;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_burst_rd.sv
// Directed bench for fsm_burst_rd: stimulus pushes expected words/strobes into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_fsm_burst_rd;
    localparam int ADDR_W = 8, DATA_W = 8, LEN_W = 4, MAX_WAIT = 15;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
    } exp_t;

    logic clk, rst;
    int   checks, failures;
    exp_t exp_q[$];
    logic [7:0] evt_q[$];

    fsm_burst_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    fsm_burst_rd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
        return a ^ 8'hB0;
    endfunction

    assign bus.mem_rdata = memf(bus.addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ds(input int exp_n, input string nm);
        int n;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.ds) begin
                n = k;
                break;
            end
        end
        check(nm, n, exp_n);
    endtask

    task automatic start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic w);
        bus.go = 1'b1; bus.start_addr = a; bus.burst_len = l; bus.ws = w;
        step();
        bus.go = 1'b0; bus.start_addr = 8'h00; bus.burst_len = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus.data_valid) begin
                if (exp_q.size() == 0) check("dv_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data_out", bus.data_out, e.d);
                    check("addr_at_dv", bus.addr, e.a);
                end
            end
            if (bus.ds) begin
                if (evt_q.size() == 0) check("ds_unexpected", 1, 0);
                else check("ds_evt", evt_q.pop_front(), "D");
            end
            if (bus.err) begin
                if (evt_q.size() == 0) check("err_unexpected", 1, 0);
                else check("err_evt", evt_q.pop_front(), "E");
            end
        end
    end

    initial begin
        int rdcnt, dscnt, errcnt, errfirst;
        logic [ADDR_W-1:0] err_addr;
        checks = 0; failures = 0;
        rst = 1'b0;
        bus.go = 1'b0; bus.abort = 1'b0; bus.start_addr = '0; bus.burst_len = '0; bus.ws = 1'b0;
        #12;
        check("rst_outs", {bus.rd, bus.busy, bus.ds, bus.err, bus.data_valid}, 5'b0);
        check("rst_addr", bus.addr, 8'h00);
        check("rst_data", bus.data_out, 8'h00);
        step();
        rst = 1'b1;
        step();

        // basic 3-word burst
        exp_q.push_back('{8'hA0, 8'h11});
        exp_q.push_back('{8'hA1, 8'h12});
        exp_q.push_back('{8'hA2, 8'h13});
        evt_q.push_back("D");
        start(8'h10, 4'd3, 1'b0);
        check("t1_busy", bus.busy, 1'b1);
        wait_ds(6, "t1_ds_lat");
        check("t1_addr", bus.addr, 8'h13);
        step();
        check("t1_idle", {bus.busy, bus.ds}, 2'b00);

        // single word with 4 wait cycles
        exp_q.push_back('{8'h90, 8'h21});
        evt_q.push_back("D");
        rdcnt = 0; dscnt = 0; errcnt = 0;
        start(8'h20, 4'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rdcnt += int'(bus.rd); dscnt += int'(bus.ds); errcnt += int'(bus.err);
            bus.ws = (i < 5);
            step();
        end
        check("t2_rd_cycles", rdcnt, 6);
        check("t2_ds_cnt", dscnt, 1);
        check("t2_err_cnt", errcnt, 0);

        // wait-state timeout
        evt_q.push_back("E");
        rdcnt = 0; dscnt = 0; errfirst = -1; err_addr = '0;
        start(8'h30, 4'd2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rdcnt += int'(bus.rd); dscnt += int'(bus.ds);
            if (bus.err && errfirst < 0) begin
                errfirst = i; err_addr = bus.addr;
            end
            step();
        end
        bus.ws = 1'b0;
        check("t3_dly_plus_read", rdcnt, 16);
        check("t3_err_at", errfirst, 16);
        check("t3_err_addr", err_addr, 8'h30);
        check("t3_no_ds", dscnt, 0);
        check("t3_idle", bus.busy, 1'b0);

        // address wrap
        exp_q.push_back('{8'h4E, 8'hFF});
        exp_q.push_back('{8'h4F, 8'h00});
        exp_q.push_back('{8'hB0, 8'h01});
        evt_q.push_back("D");
        start(8'hFE, 4'd3, 1'b0);
        wait_ds(6, "t4_ds_lat");
        check("t4_addr", bus.addr, 8'h01);
        step();

        // abort coincident with ws=0 on word 2 of 4
        exp_q.push_back('{8'hF0, 8'h41});
        dscnt = 0; errcnt = 0;
        start(8'h40, 4'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.abort = (i == 3);
            step();
        end
        bus.abort = 1'b0;
        check("t5_idle", {bus.busy, bus.rd}, 2'b00);
        check("t5_addr", bus.addr, 8'h41);
        for (int i = 0; i < 4; i++) begin
            dscnt += int'(bus.ds); errcnt += int'(bus.err);
            step();
        end
        check("t5_no_strobe", dscnt + errcnt, 0);
        bus.go = 1'b1; bus.start_addr = 8'h70; bus.burst_len = '0;
        step();
        step();
        bus.go = 1'b0;
        check("t5_len0_busy", bus.busy, 1'b0);

        // asynchronous reset in DLY
        start(8'h50, 4'd2, 1'b1);
        step();
        check("t6_in_dly", bus.rd, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_outs", {bus.rd, bus.busy, bus.ds, bus.err, bus.data_valid}, 5'b0);
        check("t6_rst_addr", bus.addr, 8'h00);
        check("t6_rst_data", bus.data_out, 8'h00);
        step();
        #3;
        rst = 1'b1;
        bus.ws = 1'b0;
        step();
        check("t6_no_strobe", {bus.ds, bus.err, bus.busy}, 3'b000);
        exp_q.push_back('{8'hD0, 8'h61});
        evt_q.push_back("D");
        start(8'h60, 4'd1, 1'b0);
        wait_ds(2, "t6_ds_lat");
        step();
        step();

        check("exp_q_empty", exp_q.size(), 0);
        check("evt_q_empty", evt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
